uart_rx_rts: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 47 ++++
 rtl/uart_rx_rts.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_rts.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and RX FSM encoding shared by the UART receive and transmit stages.
// Keeping the baud constants here means both directions use the same divider.
package uart_pkg;

  localparam int unsigned OVS        = 16;
  localparam int unsigned MID_SAMPLE = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  // Clock cycles per oversample tick, truncated.
  function automatic int unsigned ovs_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / (baud * OVS);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small receive FIFO. The caller only pushes when a slot is free or a pop happens
// in the same cycle, so no overflow guard is needed here.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    hwclk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        din,
  input  logic                    pop,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             pop_ok;

  assign pop_ok = pop && (count != '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/uart_rx_rts.sv
// 8N1 UART receiver with 16x oversampling, a small byte FIFO on a valid/ready port,
// and an rts flow-control output that keeps one slot free for a frame in flight.
module uart_rx_rts
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       hwclk,
  input  logic       rst,
  input  logic       RxD_ser,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rts,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned OVS_DIV = ovs_div(CLK_HZ, BAUD);
  localparam int unsigned TICK_W  = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  logic              sync_q1;
  logic              sync_q2;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick_c;
  rx_state_e         state;
  rx_state_e         state_next;
  logic [3:0]        s_cnt;
  logic [3:0]        s_next;
  logic [2:0]        b_cnt;
  logic [2:0]        b_next;
  logic [7:0]        shreg;
  logic [7:0]        shreg_next;
  logic              byte_done_c;
  logic              stop_bad_c;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  count_next_c;
  logic              pop_c;
  logic              push_c;
  logic              drop_c;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= RxD_ser;
      sync_q2 <= sync_q1;
    end
  end

  assign tick_c = (tick_cnt == TICK_W'(OVS_DIV - 1));

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_c ? '0 : tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s_cnt <= '0;
      b_cnt <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      s_cnt <= s_next;
      b_cnt <= b_next;
      shreg <= shreg_next;
    end
  end

  // Start-bit check at mid bit, then data and stop sampled every 16 ticks from there.
  always_comb begin
    state_next  = state;
    s_next      = s_cnt;
    b_next      = b_cnt;
    shreg_next  = shreg;
    byte_done_c = 1'b0;
    stop_bad_c  = 1'b0;
    if ((state != IDLE) && tick_c) begin
      s_next = s_cnt + 4'd1;
    end
    unique case (state)
      IDLE: begin
        if (!sync_q2) begin
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (tick_c && (s_cnt == 4'(MID_SAMPLE))) begin
          if (!sync_q2) begin
            s_next     = '0;
            b_next     = '0;
            state_next = DATA;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (tick_c && (s_cnt == 4'(OVS - 1))) begin
          shreg_next = {sync_q2, shreg[7:1]};
          if (b_cnt == 3'd7) begin
            state_next = STOP;
          end else begin
            b_next = b_cnt + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick_c && (s_cnt == 4'(OVS - 1))) begin
          byte_done_c = sync_q2;
          stop_bad_c  = !sync_q2;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A full FIFO still accepts a byte when the consumer pops in the same cycle.
  assign rx_valid     = (fifo_count != '0);
  assign pop_c        = rx_valid && rx_ready;
  assign push_c       = byte_done_c && ((fifo_count < CNT_W'(FIFO_DEPTH)) || pop_c);
  assign drop_c       = byte_done_c && !push_c;
  assign count_next_c = fifo_count + CNT_W'(push_c) - CNT_W'(pop_c);

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rts       <= 1'b0;
    end else begin
      frame_err <= stop_bad_c;
      overrun   <= drop_c;
      rts       <= (count_next_c < CNT_W'(FIFO_DEPTH - 1));
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .hwclk (hwclk),
    .rst   (rst),
    .push  (push_c),
    .din   (shreg),
    .pop   (pop_c),
    .dout  (rx_data),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_rts.sv
// Bench for uart_rx_rts: directed frames at a fast baud, a tick-offset reference
// model checked every cycle, and literal expectations for each scenario.
module tb_uart_rx_rts;
  import uart_pkg::*;

  localparam int unsigned CLK_HZ  = 12000000;
  localparam int unsigned BAUD    = 125000;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned DIV     = CLK_HZ / (BAUD * 16);
  localparam int unsigned BIT_CYC = DIV * 16;

  logic       hwclk = 1'b0;
  logic       rst;
  logic       RxD_ser;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rts;
  logic       frame_err;
  logic       overrun;

  uart_rx_rts #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .hwclk     (hwclk),
    .rst       (rst),
    .RxD_ser   (RxD_ser),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rts       (rts),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 hwclk = ~hwclk;

  // Reference model: frame timing counted in ticks since the start edge was seen.
  logic [7:0]  mq[$];
  int unsigned m_cyc;
  int unsigned m_tk;
  logic [1:0]  m_sync;
  logic        m_busy;
  logic [7:0]  m_byte;
  logic        m_ferr;
  logic        m_ovr;
  logic        m_rts;

  always @(posedge hwclk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_cyc  = 0;
      m_tk   = 0;
      m_sync = 2'b11;
      m_busy = 1'b0;
      m_byte = 8'h00;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      m_rts  = 1'b0;
    end else begin
      logic line, tick, pop, good, bad;
      line   = m_sync[1];
      m_sync = {m_sync[0], RxD_ser};
      tick   = ((m_cyc % DIV) == DIV - 1);
      m_cyc  = m_cyc + 1;
      pop    = rx_ready && (mq.size() != 0);
      good   = 1'b0;
      bad    = 1'b0;
      if (!m_busy) begin
        if (!line) begin
          m_busy = 1'b1;
          m_tk   = 0;
        end
      end else if (tick) begin
        m_tk = m_tk + 1;
        if (m_tk == 8 && line) begin
          m_busy = 1'b0;
        end else if (m_tk >= 24 && m_tk <= 136 && ((m_tk - 8) % 16) == 0) begin
          m_byte[(m_tk - 24) / 16] = line;
        end else if (m_tk == 152) begin
          m_busy = 1'b0;
          good   = line;
          bad    = !line;
        end
      end
      if (pop) void'(mq.pop_front());
      m_ovr = 1'b0;
      if (good) begin
        if (mq.size() < DEPTH) mq.push_back(m_byte);
        else m_ovr = 1'b1;
      end
      m_ferr = bad;
      m_rts  = (mq.size() < DEPTH - 1);
    end
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  int         valid_cycles;
  int         ferr_seen;
  int         ovr_seen;
  logic [7:0] last_data;
  time        t_first;
  time        t0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_loop();
    forever begin
      logic       exp_valid;
      logic [7:0] exp_data;
      @(negedge hwclk);
      exp_valid = (mq.size() != 0);
      exp_data  = exp_valid ? mq[0] : 8'h00;
      n_tests++;
      if (rx_valid !== exp_valid || rts !== m_rts || frame_err !== m_ferr ||
          overrun !== m_ovr || (exp_valid && rx_data !== exp_data)) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got v=%b d=%h rts=%b fe=%b ov=%b exp v=%b d=%h rts=%b fe=%b ov=%b",
                 $time, rx_valid, rx_data, rts, frame_err, overrun,
                 exp_valid, exp_data, m_rts, m_ferr, m_ovr);
      end
      if (rx_valid === 1'b1) begin
        if (valid_cycles == 0) t_first = $time;
        valid_cycles++;
        last_data = rx_data;
      end
      if (frame_err === 1'b1) ferr_seen++;
      if (overrun === 1'b1) ovr_seen++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge hwclk);
  endtask

  task automatic clear_mon();
    valid_cycles = 0;
    ferr_seen    = 0;
    ovr_seen     = 0;
    last_data    = 8'h00;
    t_first      = 0;
  endtask

  // Bad stop is held low only past its midpoint so the restart check sees idle.
  task automatic send_frame(input logic [7:0] d, input logic good_stop);
    RxD_ser = 1'b0;
    idle(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      RxD_ser = d[i];
      idle(BIT_CYC);
    end
    if (good_stop) begin
      RxD_ser = 1'b1;
      idle(BIT_CYC);
    end else begin
      RxD_ser = 1'b0;
      idle(BIT_CYC * 5 / 8);
      RxD_ser = 1'b1;
      idle(BIT_CYC - BIT_CYC * 5 / 8);
    end
    RxD_ser = 1'b1;
    idle(BIT_CYC);
  endtask

  task automatic pop_one(output logic [7:0] d);
    d        = rx_data;
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
  endtask

  logic [7:0] d;
  int         lat;
  int         waited;
  logic [7:0] part;

  initial begin
    rst      = 1'b1;
    RxD_ser  = 1'b1;
    rx_ready = 1'b1;
    clear_mon();
    fork
      compare_loop();
    join_none

    check("ovs_div_9600", ovs_div(32'd12000000, 32'd9600), 32'd78);
    idle(3);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rts", 32'(rts), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    idle(1);
    check("rts_after_reset", 32'(rts), 32'd1);
    idle(4);

    // Single frame, consumer always ready.
    clear_mon();
    t0 = $time;
    send_frame(8'h55, 1'b1);
    check("f55_valid_cycles", 32'(valid_cycles), 32'd1);
    check("f55_data", 32'(last_data), 32'h55);
    check("f55_no_errs", 32'(ferr_seen + ovr_seen), 32'd0);
    lat = int'((t_first - t0) / 10);
    n_tests++;
    if (lat < 905 || lat > 920) begin
      n_fail++;
      $display("FAIL f55_latency: got %0d cycles expected about 912", lat);
    end

    // Three-tick glitch on an idle line.
    clear_mon();
    RxD_ser = 1'b0;
    idle(3 * DIV);
    RxD_ser = 1'b1;
    idle(3 * BIT_CYC);
    check("glitch_no_valid", 32'(valid_cycles), 32'd0);
    check("glitch_no_pulses", 32'(ferr_seen + ovr_seen), 32'd0);

    // Bad stop bit, then a good frame.
    clear_mon();
    send_frame(8'hA3, 1'b0);
    idle(BIT_CYC);
    check("a3_frame_err_once", 32'(ferr_seen), 32'd1);
    check("a3_no_valid", 32'(valid_cycles), 32'd0);
    check("a3_no_overrun", 32'(ovr_seen), 32'd0);
    clear_mon();
    send_frame(8'h3C, 1'b1);
    check("f3c_valid_cycles", 32'(valid_cycles), 32'd1);
    check("f3c_data", 32'(last_data), 32'h3C);
    check("f3c_no_ferr", 32'(ferr_seen), 32'd0);

    // Fill with consumer stalled, overrun the fifth byte, then drain.
    rx_ready = 1'b0;
    clear_mon();
    send_frame(8'h01, 1'b1);
    check("fill1_rts", 32'(rts), 32'd1);
    send_frame(8'h02, 1'b1);
    check("fill2_rts", 32'(rts), 32'd1);
    send_frame(8'h03, 1'b1);
    check("fill3_rts", 32'(rts), 32'd0);
    check("fill3_head", 32'(rx_data), 32'h01);
    send_frame(8'h04, 1'b1);
    check("fill4_head", 32'(rx_data), 32'h01);
    check("fill4_no_overrun", 32'(ovr_seen), 32'd0);
    send_frame(8'h05, 1'b1);
    check("fill5_overrun", 32'(ovr_seen), 32'd1);
    check("fill5_head", 32'(rx_data), 32'h01);
    pop_one(d);
    check("drain1", 32'(d), 32'h01);
    check("drain1_rts", 32'(rts), 32'd0);
    pop_one(d);
    check("drain2", 32'(d), 32'h02);
    check("drain2_rts", 32'(rts), 32'd1);
    pop_one(d);
    check("drain3", 32'(d), 32'h03);
    pop_one(d);
    check("drain4", 32'(d), 32'h04);
    check("drain_empty", 32'(rx_valid), 32'd0);

    // Full FIFO with a pop on exactly the push cycle of 0x77.
    clear_mon();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    check("full_rts", 32'(rts), 32'd0);
    waited = 0;
    fork
      send_frame(8'h77, 1'b1);
      begin
        while (!(m_busy && m_tk == 151 && (m_cyc % DIV) == DIV - 1) && waited < 12 * BIT_CYC) begin
          idle(1);
          waited++;
        end
        check("push_cycle_found", 32'(waited < 12 * BIT_CYC), 32'd1);
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
      end
    join
    check("p77_no_overrun", 32'(ovr_seen), 32'd0);
    pop_one(d);
    check("p77_drain1", 32'(d), 32'h22);
    pop_one(d);
    check("p77_drain2", 32'(d), 32'h33);
    pop_one(d);
    check("p77_drain3", 32'(d), 32'h44);
    pop_one(d);
    check("p77_last", 32'(d), 32'h77);
    check("p77_empty", 32'(rx_valid), 32'd0);

    // Reset during data bit 4 with one byte buffered.
    send_frame(8'h66, 1'b1);
    check("pre_rst_valid", 32'(rx_valid), 32'd1);
    part    = 8'h5A;
    RxD_ser = 1'b0;
    idle(BIT_CYC);
    for (int i = 0; i < 4; i++) begin
      RxD_ser = part[i];
      idle(BIT_CYC);
    end
    RxD_ser = part[4];
    idle(BIT_CYC / 2);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 32'(rx_valid), 32'd0);
    check("midrst_data", 32'(rx_data), 32'd0);
    check("midrst_rts", 32'(rts), 32'd0);
    check("midrst_pulses", 32'(frame_err | overrun), 32'd0);
    RxD_ser = 1'b1;
    idle(3);
    rst = 1'b0;
    clear_mon();
    idle(1);
    check("postrst_rts", 32'(rts), 32'd1);
    idle(2 * BIT_CYC);
    check("postrst_no_pulses", 32'(ferr_seen + ovr_seen + valid_cycles), 32'd0);
    rx_ready = 1'b1;
    send_frame(8'h9E, 1'b1);
    check("f9e_valid_cycles", 32'(valid_cycles), 32'd1);
    check("f9e_data", 32'(last_data), 32'h9E);
    check("f9e_rts", 32'(rts), 32'd1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
